// File: rtl/sc_nest_lives_tracker.sv
// Nest/lives/level tracker for the frog game: edge-detects nest and hit strobes,
// runs the IDLE/PLAY/GUARD/NESTS_DONE/GAME_OVER flow and drives registered status back to the main FSM.
module sc_nest_lives_tracker #(
  parameter int NUM_NESTS      = 5,
  parameter int LIVES_INIT     = 3,
  parameter int LIVES_WIDTH    = 3,
  parameter int RESPAWN_CYCLES = 16,
  parameter int RESPAWN_WIDTH  = 5
) (
  input  logic                   SC_NESTLIVES_CLOCK_50,
  input  logic                   SC_NESTLIVES_RESET_InHigh,
  input  logic                   SC_NESTLIVES_load_InLow,
  input  logic                   SC_NESTLIVES_resetFrog_InLow,
  input  logic [2:0]             SC_NESTLIVES_transition_InBUS,
  input  logic                   SC_NESTLIVES_nestEntry_InLow,
  input  logic [2:0]             SC_NESTLIVES_nestIndex_InBUS,
  input  logic                   SC_NESTLIVES_frogHit_InLow,
  output logic                   SC_NESTLIVES_nidosCompletos_OutLow,
  output logic                   SC_NESTLIVES_PerdioVidas_OutLow,
  output logic                   SC_NESTLIVES_respawn_OutLow,
  output logic [LIVES_WIDTH-1:0] SC_NESTLIVES_lives_OutBUS,
  output logic [NUM_NESTS-1:0]   SC_NESTLIVES_nestMask_OutBUS,
  output logic [2:0]             SC_NESTLIVES_level_OutBUS
);

  typedef enum logic [2:0] {IDLE, PLAY, GUARD, NESTS_DONE, GAME_OVER} state_t;

  logic clk, rst;
  assign clk = SC_NESTLIVES_CLOCK_50;
  assign rst = SC_NESTLIVES_RESET_InHigh;

  state_t                   state_q, state_d;
  logic [LIVES_WIDTH-1:0]   lives_q, lives_d;
  logic [NUM_NESTS-1:0]     mask_q, mask_d;
  logic [2:0]               level_q, level_d;
  logic [RESPAWN_WIDTH-1:0] cnt_q, cnt_d;
  logic                     nidos_q, nidos_d;
  logic                     perdio_q, perdio_d;
  logic                     respawn_q, respawn_d;
  logic                     nest_s1_q, nest_s1_d, nest_s2_q, nest_s2_d;
  logic                     hit_s1_q, hit_s1_d, hit_s2_q, hit_s2_d;
  logic [2:0]               idx_q, idx_d;

  logic nest_ev, hit_ev, idx_valid, do_hit;
  logic [2:0] trans;

  // Index is captured alongside the nest strobe so it stays paired with the falling edge
  assign nest_ev   = nest_s2_q & ~nest_s1_q;
  assign hit_ev    = hit_s2_q & ~hit_s1_q;
  assign idx_valid = int'(idx_q) < NUM_NESTS;
  assign trans     = SC_NESTLIVES_transition_InBUS;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    mask_d    = mask_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    nidos_d   = nidos_q;
    perdio_d  = perdio_q;
    respawn_d = 1'b1;
    nest_s1_d = SC_NESTLIVES_nestEntry_InLow;
    nest_s2_d = nest_s1_q;
    hit_s1_d  = SC_NESTLIVES_frogHit_InLow;
    hit_s2_d  = hit_s1_q;
    idx_d     = SC_NESTLIVES_nestIndex_InBUS;
    do_hit    = 1'b0;

    if (!SC_NESTLIVES_load_InLow) begin
      state_d  = IDLE;
      lives_d  = LIVES_WIDTH'(LIVES_INIT);
      mask_d   = '0;
      level_d  = '0;
      cnt_d    = '0;
      nidos_d  = 1'b1;
      perdio_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (trans == 3'b001) begin
            level_d = 3'd1;
            state_d = PLAY;
          end
        end
        PLAY: begin
          // A nest event takes precedence; a same-cycle hit is dropped
          if (nest_ev) begin
            if (idx_valid && !mask_q[idx_q]) begin
              for (int i = 0; i < NUM_NESTS; i++) begin
                if (int'(idx_q) == i) mask_d[i] = 1'b1;
              end
              if (&mask_d) begin
                state_d = NESTS_DONE;
                nidos_d = 1'b0;
              end
            end else begin
              do_hit = 1'b1;
            end
          end else if (hit_ev) begin
            do_hit = 1'b1;
          end
          if (do_hit) begin
            if (lives_q <= LIVES_WIDTH'(1)) begin
              lives_d  = '0;
              state_d  = GAME_OVER;
              perdio_d = 1'b0;
            end else begin
              lives_d   = lives_q - LIVES_WIDTH'(1);
              respawn_d = 1'b0;
              cnt_d     = RESPAWN_WIDTH'(RESPAWN_CYCLES);
              state_d   = GUARD;
            end
          end
        end
        GUARD: begin
          if (!SC_NESTLIVES_resetFrog_InLow || cnt_q <= RESPAWN_WIDTH'(1)) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q - RESPAWN_WIDTH'(1);
          end
        end
        NESTS_DONE: begin
          if (trans >= 3'b001 && trans <= 3'b100) begin
            level_d = trans;
            mask_d  = '0;
            nidos_d = 1'b1;
            state_d = PLAY;
          end else if (trans == 3'b101) begin
            mask_d  = '0;
            nidos_d = 1'b1;
            state_d = IDLE;
          end
        end
        GAME_OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lives_q   <= LIVES_WIDTH'(LIVES_INIT);
      mask_q    <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      nidos_q   <= 1'b1;
      perdio_q  <= 1'b1;
      respawn_q <= 1'b1;
      nest_s1_q <= 1'b1;
      nest_s2_q <= 1'b1;
      hit_s1_q  <= 1'b1;
      hit_s2_q  <= 1'b1;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      mask_q    <= mask_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      nidos_q   <= nidos_d;
      perdio_q  <= perdio_d;
      respawn_q <= respawn_d;
      nest_s1_q <= nest_s1_d;
      nest_s2_q <= nest_s2_d;
      hit_s1_q  <= hit_s1_d;
      hit_s2_q  <= hit_s2_d;
      idx_q     <= idx_d;
    end
  end

  assign SC_NESTLIVES_nidosCompletos_OutLow = nidos_q;
  assign SC_NESTLIVES_PerdioVidas_OutLow    = perdio_q;
  assign SC_NESTLIVES_respawn_OutLow        = respawn_q;
  assign SC_NESTLIVES_lives_OutBUS          = lives_q;
  assign SC_NESTLIVES_nestMask_OutBUS       = mask_q;
  assign SC_NESTLIVES_level_OutBUS          = level_q;

endmodule

// File: tb/tb_sc_nest_lives_tracker.sv
// Directed + randomized bench for sc_nest_lives_tracker against an event-level game model.
module tb_sc_nest_lives_tracker;
  localparam int NN = 5, LI = 3, LW = 3, RC = 16, RW = 5;

  logic clk = 1'b0;
  logic rst, load_n, rf_n, nest_n, hit_n;
  logic [2:0] trans, idx;
  logic nidos_n, perdio_n, respawn_n;
  logic [LW-1:0] lives;
  logic [NN-1:0] mask;
  logic [2:0] level;

  sc_nest_lives_tracker #(.NUM_NESTS(NN), .LIVES_INIT(LI), .LIVES_WIDTH(LW),
                          .RESPAWN_CYCLES(RC), .RESPAWN_WIDTH(RW)) dut (
    .SC_NESTLIVES_CLOCK_50(clk),
    .SC_NESTLIVES_RESET_InHigh(rst),
    .SC_NESTLIVES_load_InLow(load_n),
    .SC_NESTLIVES_resetFrog_InLow(rf_n),
    .SC_NESTLIVES_transition_InBUS(trans),
    .SC_NESTLIVES_nestEntry_InLow(nest_n),
    .SC_NESTLIVES_nestIndex_InBUS(idx),
    .SC_NESTLIVES_frogHit_InLow(hit_n),
    .SC_NESTLIVES_nidosCompletos_OutLow(nidos_n),
    .SC_NESTLIVES_PerdioVidas_OutLow(perdio_n),
    .SC_NESTLIVES_respawn_OutLow(respawn_n),
    .SC_NESTLIVES_lives_OutBUS(lives),
    .SC_NESTLIVES_nestMask_OutBUS(mask),
    .SC_NESTLIVES_level_OutBUS(level)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // Model: mode 0 idle, 1 play, 2 all nests done, 3 game over
  int m_lives, m_level, m_mode, m_mask;
  int resp_lows;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_lives = LI; m_level = 0; m_mode = 0; m_mask = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/lives"}, 32'(lives), m_lives);
    chk({tag, "/mask"}, 32'(mask), m_mask);
    chk({tag, "/level"}, 32'(level), m_level);
    chk({tag, "/nidos"}, 32'(nidos_n), (m_mode == 2) ? 0 : 1);
    chk({tag, "/perdio"}, 32'(perdio_n), (m_mode == 3) ? 0 : 1);
    chk({tag, "/respawn_idle"}, 32'(respawn_n), 1);
    $display("step %-14s lives=%0d mask=%b level=%0d nidos=%b perdio=%b", tag, lives, mask, level, nidos_n, perdio_n);
  endtask

  // Returns number of respawn pulses the game rules predict for this event
  function automatic int model_event(input bit nest, input bit hit, input int ix);
    bit lose;
    lose = 1'b0;
    if (m_mode != 1) return 0;
    if (nest) begin
      if (ix < NN && ((m_mask >> ix) & 1) == 0) begin
        m_mask = m_mask | (1 << ix);
        if (m_mask == (1 << NN) - 1) m_mode = 2;
      end else lose = 1'b1;
    end else if (hit) lose = 1'b1;
    if (!lose) return 0;
    m_lives = m_lives - 1;
    if (m_lives == 0) begin
      m_mode = 3;
      return 0;
    end
    return 1;
  endfunction

  task automatic m_trans(input int code);
    if (m_mode == 0 && code == 1) begin
      m_level = 1; m_mode = 1;
    end else if (m_mode == 2 && code >= 1 && code <= 4) begin
      m_level = code; m_mask = 0; m_mode = 1;
    end else if (m_mode == 2 && code == 5) begin
      m_mask = 0; m_mode = 0;
    end
  endtask

  task automatic do_event(input bit nest, input bit hit, input int ix, input int gap);
    resp_lows = 0;
    nest_n = ~nest; hit_n = ~hit; idx = 3'(ix);
    tick(1);
    nest_n = 1'b1; hit_n = 1'b1;
    repeat (gap) begin
      if (respawn_n == 1'b0) resp_lows++;
      tick(1);
    end
  endtask

  task automatic do_op(input bit nest, input bit hit, input int ix, input string tag);
    int exp_resp;
    exp_resp = model_event(nest, hit, ix);
    do_event(nest, hit, ix, RC + 4);
    chk({tag, "/respawn_pulses"}, resp_lows, exp_resp);
    check_all(tag);
  endtask

  task automatic do_trans(input int code, input string tag);
    trans = 3'(code);
    tick(2);
    trans = 3'b000;
    tick(1);
    m_trans(code);
    check_all(tag);
  endtask

  task automatic do_load(input string tag);
    load_n = 1'b0;
    tick(1);
    load_n = 1'b1;
    tick(1);
    m_reset();
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; load_n = 1'b1; rf_n = 1'b1; nest_n = 1'b1; hit_n = 1'b1;
    trans = 3'b000; idx = 3'd0;
    m_reset();
    tick(2);
    check_all("reset");
    rst = 1'b0;
    tick(1);

    // 1: fill all nests, advance to level 2
    do_trans(1, "t1_start");
    for (int i = 0; i < NN; i++) do_op(1'b1, 1'b0, i, "t1_nest");
    do_trans(2, "t1_level2");

    // 2: three hits exhaust lives, load recovers
    do_load("t2_load");
    do_trans(1, "t2_start");
    for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, 0, "t2_hit");
    do_load("t2_reload");
    do_op(1'b0, 1'b1, 0, "t2_idle_hit");

    // 3: second hit inside the guard window is ignored
    do_trans(1, "t3_start");
    resp_lows = model_event(1'b0, 1'b1, 0);
    do_event(1'b0, 1'b1, 0, 4);
    chk("t3_first_pulse", resp_lows, 1);
    do_event(1'b0, 1'b1, 0, RC + 4);
    chk("t3_guard_pulse", resp_lows, 0);
    check_all("t3_after");

    // 4: repeated nest costs a life; nest+hit same edge keeps lives; bad index is a hit
    do_load("t4_load");
    do_trans(1, "t4_start");
    do_op(1'b1, 1'b0, 2, "t4_nest2");
    do_op(1'b1, 1'b0, 2, "t4_nest2_again");
    do_op(1'b1, 1'b1, 3, "t4_nest_and_hit");
    do_op(1'b1, 1'b0, 6, "t4_bad_index");

    // 5: held hit costs one life; resetFrog ends the guard early
    do_load("t5_load");
    do_trans(1, "t5_start");
    resp_lows = 0;
    hit_n = 1'b0;
    repeat (100) begin
      if (respawn_n == 1'b0) resp_lows++;
      tick(1);
    end
    hit_n = 1'b1;
    tick(2);
    chk("t5_held_pulses", resp_lows, model_event(1'b0, 1'b1, 0));
    check_all("t5_held");
    void'(model_event(1'b0, 1'b1, 0));
    do_event(1'b0, 1'b1, 0, 3);
    rf_n = 1'b0;
    tick(1);
    rf_n = 1'b1;
    void'(model_event(1'b1, 1'b0, 4));
    do_event(1'b1, 1'b0, 4, 3);
    check_all("t5_resetfrog");

    // 6: async reset while the done flag is held, then the final-level path
    do_load("t6_load");
    do_trans(1, "t6_start");
    for (int i = 0; i < NN; i++) do_op(1'b1, 1'b0, i, "t6_nest");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    m_reset();
    check_all("t6_async_rst");
    tick(1);
    rst = 1'b0;
    do_trans(1, "t6_restart");
    for (int i = NN - 1; i >= 0; i--) do_op(1'b1, 1'b0, i, "t6_nest_b");
    do_trans(5, "t6_final");
    do_trans(2, "t6_idle_ign");
    do_trans(1, "t6_idle_go");
    do_op(1'b1, 1'b0, 1, "t6_play");

    // Randomized play against the model
    do_load("rnd_load");
    for (int n = 0; n < 60; n++) begin
      int r;
      if (m_mode == 3) do_load("rnd_reload");
      else if (m_mode == 0) do_trans(1, "rnd_start");
      else if (m_mode == 2) do_trans($urandom_range(1, 7), "rnd_trans");
      else begin
        r = $urandom_range(0, 5);
        case (r)
          0, 1, 2: do_op(1'b1, 1'b0, $urandom_range(0, 5), "rnd_nest");
          3:       do_op(1'b0, 1'b1, 0, "rnd_hit");
          4:       do_op(1'b1, 1'b1, $urandom_range(0, 7), "rnd_both");
          default: do_trans($urandom_range(6, 7), "rnd_badcode");
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
